// File: rtl/s386_tb_pkg.sv
// ---------------------------------------------------------------------------
// s386_tb_pkg
// Purpose : Shared types and constants for the s386 response compactor.
//           Holds the FSM state encoding, the default response width, the
//           default MISR polynomial/seed, and the bit-order mapping of the
//           core's primary outputs onto the response bus.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package s386_tb_pkg;

  // Number of s386 primary outputs folded into the signature.
  localparam int PKG_RESP_W = 7;

  // Default MISR feedback taps and start value.
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // Compactor FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit order of resp_in: the first member is the MSB, so bit 6 carries
  // v13_D_12 and bit 0 carries v13_D_6.
  typedef struct packed {
    logic v13_D_12;
    logic v13_D_11;
    logic v13_D_10;
    logic v13_D_9;
    logic v13_D_8;
    logic v13_D_7;
    logic v13_D_6;
  } resp_bits_t;

endpackage

// File: rtl/s386_resp_compactor_if.sv
// ---------------------------------------------------------------------------
// s386_resp_compactor_if
// Purpose : Control/response bundle between the test harness (master) and
//           the response compactor (slave).
// Signals : start, abort, num_cycles, resp_valid, resp_in, expected_sig
//           (master -> slave); busy, done, signature, toggle_count, match
//           (slave -> master).
// ---------------------------------------------------------------------------
interface s386_resp_compactor_if #(
  parameter int RESP_W = 7,
  parameter int SIG_W  = 16,
  parameter int CNT_W  = 16
);

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_cycles;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_in;
  logic [SIG_W-1:0]  expected_sig;

  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  toggle_count;
  logic              match;

  modport master (
    output start, abort, num_cycles, resp_valid, resp_in, expected_sig,
    input  busy, done, signature, toggle_count, match
  );

  modport slave (
    input  start, abort, num_cycles, resp_valid, resp_in, expected_sig,
    output busy, done, signature, toggle_count, match
  );

endinterface

// File: rtl/misr_reg.sv
// ---------------------------------------------------------------------------
// misr_reg
// Purpose : Multiple-input signature register. Shifts left, folds the MSB
//           back through the POLY tap mask and XORs in the zero-extended
//           response sample.
// Ports   : i_clk, i_reset (async, active-high) - clock / reset
//           i_load     - load SEED next edge (wins over i_enable)
//           i_enable   - perform one MISR update next edge
//           i_in       - response sample
//           o_sig      - current signature
//           o_sig_upd  - value the signature takes if updated this cycle
// ---------------------------------------------------------------------------
module misr_reg #(
  parameter int               SIG_W  = 16,
  parameter int               RESP_W = 7,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_enable,
  input  logic [RESP_W-1:0] i_in,
  output logic [SIG_W-1:0]  o_sig,
  output logic [SIG_W-1:0]  o_sig_upd
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_ext;
  logic [SIG_W-1:0] w_upd;
  logic [SIG_W-1:0] w_next;

  // Zero-extend written bitwise so SIG_W == RESP_W needs no empty replication.
  always_comb begin
    w_ext = '0;
    w_ext[RESP_W-1:0] = i_in;
    w_upd = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_ext;
    w_next = r_sig;
    if (i_load) begin
      w_next = SEED;
    end else if (i_enable) begin
      w_next = w_upd;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sig <= SEED;
    end else begin
      r_sig <= w_next;
    end
  end

  assign o_sig     = r_sig;
  assign o_sig_upd = w_upd;

endmodule

// File: rtl/s386_resp_compactor.sv
// ---------------------------------------------------------------------------
// s386_resp_compactor
// Purpose : Compacts the s386 core's primary outputs over a programmable
//           window into a MISR signature and a saturating toggle count, and
//           compares the final signature against a golden value.
// Ports   : blif_clk_net   - clock, rising edge
//           blif_reset_net - asynchronous, active-high reset
//           bus (slave)    - start/abort/num_cycles/resp_valid/resp_in/
//                            expected_sig in; busy/done/signature/
//                            toggle_count/match out
// ---------------------------------------------------------------------------
module s386_resp_compactor
  import s386_tb_pkg::*;
#(
  parameter int               RESP_W = PKG_RESP_W,
  parameter int               SIG_W  = 16,
  parameter int               CNT_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
  input logic                  blif_clk_net,
  input logic                  blif_reset_net,
  s386_resp_compactor_if.slave bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_remaining;
  logic [RESP_W-1:0] r_prev_resp;
  logic [CNT_W-1:0]  r_toggle;
  logic              r_match;

  logic              w_misr_load;
  logic              w_misr_en;
  logic [SIG_W-1:0]  w_sig;
  logic [SIG_W-1:0]  w_sig_upd;
  logic [RESP_W-1:0] w_diff;
  logic [CNT_W:0]    w_pop;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_toggle_sat;

  misr_reg #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .i_clk     (blif_clk_net),
    .i_reset   (blif_reset_net),
    .i_load    (w_misr_load),
    .i_enable  (w_misr_en),
    .i_in      (bus.resp_in),
    .o_sig     (w_sig),
    .o_sig_upd (w_sig_upd)
  );

  // The sum is one bit wider than the counter, so its carry flags overflow;
  // a single sample adds at most RESP_W, which always fits below 2*max.
  always_comb begin
    w_diff = bus.resp_in ^ r_prev_resp;
    w_pop  = '0;
    for (int i = 0; i < RESP_W; i++) begin
      w_pop = w_pop + (CNT_W+1)'(w_diff[i]);
    end
    w_sum        = {1'b0, r_toggle} + w_pop;
    w_toggle_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  // Abort outranks everything; start only counts in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_misr_load  = 1'b0;
    w_misr_en    = 1'b0;
    if (bus.abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_misr_load  = 1'b1;
            w_state_next = (bus.num_cycles == '0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.resp_valid) begin
            w_misr_en = 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              w_state_next = DONE;
            end
          end
        end
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // match is loaded on the edge that enters DONE, compared against the value
  // the signature takes on that same edge, so it is valid together with done.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_prev_resp <= '0;
      r_toggle    <= '0;
      r_match     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (bus.abort) begin
        r_match <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_toggle    <= '0;
              r_prev_resp <= '0;
              r_remaining <= bus.num_cycles;
              r_match     <= (bus.num_cycles == '0) ? (SEED == bus.expected_sig) : 1'b0;
            end
          end
          CAPTURE: begin
            if (bus.resp_valid) begin
              r_toggle    <= w_toggle_sat;
              r_prev_resp <= bus.resp_in;
              r_remaining <= (r_remaining != '0) ? r_remaining - CNT_W'(1) : '0;
              if (r_remaining == CNT_W'(1)) begin
                r_match <= (w_sig_upd == bus.expected_sig);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy         = (r_state == CAPTURE);
  assign bus.done         = (r_state == DONE);
  assign bus.signature    = w_sig;
  assign bus.toggle_count = r_toggle;
  assign bus.match        = r_match;

endmodule

// File: tb/tb_s386_resp_compactor.sv
// ---------------------------------------------------------------------------
// tb_s386_resp_compactor
// Purpose : Directed self-checking bench for s386_resp_compactor. One DUT
//           uses the default configuration (SEED=0, CNT_W=16); a second one
//           (SEED=16'h8000, CNT_W=4) exercises the feedback tap and the
//           toggle-counter saturation.
// ---------------------------------------------------------------------------
module tb_s386_resp_compactor;

  logic blif_clk_net;
  logic blif_reset_net;

  int nChecks;
  int nPass;

  s386_resp_compactor_if #(.RESP_W(7), .SIG_W(16), .CNT_W(16)) b  ();
  s386_resp_compactor_if #(.RESP_W(7), .SIG_W(16), .CNT_W(4))  bs ();

  s386_resp_compactor #(
    .RESP_W (7), .SIG_W (16), .CNT_W (16), .POLY (16'h1021), .SEED (16'h0000)
  ) dut (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .bus            (b.slave)
  );

  s386_resp_compactor #(
    .RESP_W (7), .SIG_W (16), .CNT_W (4), .POLY (16'h1021), .SEED (16'h8000)
  ) dut_sat (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .bus            (bs.slave)
  );

  initial begin
    blif_clk_net = 1'b0;
    forever #5 blif_clk_net = ~blif_clk_net;
  end

  // Step to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge blif_clk_net);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive the default DUT's inputs, then let one edge consume them.
  task automatic applyStimulus(input logic st, input logic ab, input logic [15:0] num,
                               input logic vld, input logic [6:0] rin, input logic [15:0] exp);
    b.start        = st;
    b.abort        = ab;
    b.num_cycles   = num;
    b.resp_valid   = vld;
    b.resp_in      = rin;
    b.expected_sig = exp;
    tick();
  endtask

  task automatic applySat(input logic st, input logic [3:0] num, input logic vld,
                          input logic [6:0] rin, input logic [15:0] exp);
    bs.start        = st;
    bs.abort        = 1'b0;
    bs.num_cycles   = num;
    bs.resp_valid   = vld;
    bs.resp_in      = rin;
    bs.expected_sig = exp;
    tick();
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    blif_reset_net = 1'b1;
    b.start = 0; b.abort = 0; b.num_cycles = '0; b.resp_valid = 0; b.resp_in = '0; b.expected_sig = '0;
    bs.start = 0; bs.abort = 0; bs.num_cycles = '0; bs.resp_valid = 0; bs.resp_in = '0; bs.expected_sig = '0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(b.busy), 32'h0);
    checkOutput("rst_done", 32'(b.done), 32'h0);
    checkOutput("rst_sig", 32'(b.signature), 32'h0);
    checkOutput("rst_tog", 32'(b.toggle_count), 32'h0);
    checkOutput("rst_match", 32'(b.match), 32'h0);
    checkOutput("rst_sat_sig", 32'(bs.signature), 32'h8000);
    blif_reset_net = 1'b0;
    tick();

    // Basic compaction: one sample 7'h55 from SEED 0.
    applyStimulus(1, 0, 16'd1, 0, 7'h00, 16'h0055);
    checkOutput("t1_busy", 32'(b.busy), 32'h1);
    applyStimulus(0, 0, 16'd0, 1, 7'h55, 16'h0055);
    checkOutput("t1_done", 32'(b.done), 32'h1);
    checkOutput("t1_sig", 32'(b.signature), 32'h0055);
    checkOutput("t1_tog", 32'(b.toggle_count), 32'd4);
    checkOutput("t1_match", 32'(b.match), 32'h1);
    checkOutput("t1_busy_done", 32'(b.busy), 32'h0);
    applyStimulus(0, 0, 16'd0, 0, 7'h00, 16'h0055);
    checkOutput("t1_done_end", 32'(b.done), 32'h0);
    checkOutput("t1_sig_hold", 32'(b.signature), 32'h0055);

    // Two samples 7'h55 then 7'h00: shift only -> 16'h00AA.
    applyStimulus(1, 0, 16'd2, 0, 7'h00, 16'h00AA);
    checkOutput("t2_match_clr", 32'(b.match), 32'h0);
    applyStimulus(0, 0, 16'd0, 1, 7'h55, 16'h00AA);
    checkOutput("t2_sig1", 32'(b.signature), 32'h0055);
    checkOutput("t2_done_early", 32'(b.done), 32'h0);
    applyStimulus(0, 0, 16'd0, 1, 7'h00, 16'h00AA);
    checkOutput("t2_sig", 32'(b.signature), 32'h00AA);
    checkOutput("t2_tog", 32'(b.toggle_count), 32'd8);
    checkOutput("t2_done", 32'(b.done), 32'h1);
    applyStimulus(0, 0, 16'd0, 0, 7'h00, 16'h00AA);

    // Stall: 7'h7F, three idle cycles, 7'h00.
    applyStimulus(1, 0, 16'd2, 0, 7'h00, 16'h00FE);
    applyStimulus(0, 0, 16'd0, 1, 7'h7F, 16'h00FE);
    checkOutput("t3_sig1", 32'(b.signature), 32'h007F);
    checkOutput("t3_tog1", 32'(b.toggle_count), 32'd7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 16'd0, 0, 7'h15, 16'h00FE);
      checkOutput("t3_stall_sig", 32'(b.signature), 32'h007F);
      checkOutput("t3_stall_done", 32'(b.done), 32'h0);
      checkOutput("t3_stall_busy", 32'(b.busy), 32'h1);
    end
    applyStimulus(0, 0, 16'd0, 1, 7'h00, 16'h00FE);
    checkOutput("t3_done", 32'(b.done), 32'h1);
    checkOutput("t3_sig", 32'(b.signature), 32'h00FE);
    checkOutput("t3_tog", 32'(b.toggle_count), 32'd14);
    checkOutput("t3_match", 32'(b.match), 32'h1);
    applyStimulus(0, 0, 16'd0, 0, 7'h00, 16'h00FE);
    checkOutput("t3_done_end", 32'(b.done), 32'h0);

    // Zero window: straight to DONE with SEED compared.
    applyStimulus(1, 0, 16'd0, 0, 7'h00, 16'h0000);
    checkOutput("t4_done", 32'(b.done), 32'h1);
    checkOutput("t4_match", 32'(b.match), 32'h1);
    checkOutput("t4_sig", 32'(b.signature), 32'h0000);
    checkOutput("t4_tog", 32'(b.toggle_count), 32'h0);
    applyStimulus(0, 0, 16'd0, 0, 7'h00, 16'h0000);
    checkOutput("t4_done_end", 32'(b.done), 32'h0);
    applyStimulus(1, 0, 16'd0, 0, 7'h00, 16'h0001);
    checkOutput("t4b_done", 32'(b.done), 32'h1);
    checkOutput("t4b_match", 32'(b.match), 32'h0);
    applyStimulus(0, 0, 16'd0, 0, 7'h00, 16'h0001);

    // Abort after two of five samples; abort also beats start and resp_valid.
    applyStimulus(1, 0, 16'd5, 0, 7'h00, 16'h002E);
    applyStimulus(0, 0, 16'd0, 1, 7'h0F, 16'h002E);
    applyStimulus(0, 0, 16'd0, 1, 7'h30, 16'h002E);
    checkOutput("t5_sig2", 32'(b.signature), 32'h002E);
    applyStimulus(1, 1, 16'd5, 1, 7'h7F, 16'h002E);
    checkOutput("t5_busy", 32'(b.busy), 32'h0);
    checkOutput("t5_done", 32'(b.done), 32'h0);
    checkOutput("t5_sig", 32'(b.signature), 32'h002E);
    checkOutput("t5_tog", 32'(b.toggle_count), 32'd10);
    checkOutput("t5_match", 32'(b.match), 32'h0);
    applyStimulus(0, 0, 16'd0, 0, 7'h00, 16'h002E);
    checkOutput("t5_no_done", 32'(b.done), 32'h0);
    checkOutput("t5_idle", 32'(b.busy), 32'h0);

    // start during CAPTURE must neither reload nor change the sample count.
    applyStimulus(1, 0, 16'd3, 0, 7'h00, 16'h0004);
    applyStimulus(0, 0, 16'd0, 1, 7'h01, 16'h0004);
    checkOutput("t6_sig1", 32'(b.signature), 32'h0001);
    applyStimulus(1, 0, 16'd9, 1, 7'h02, 16'h0004);
    checkOutput("t6_sig2", 32'(b.signature), 32'h0000);
    checkOutput("t6_busy", 32'(b.busy), 32'h1);
    applyStimulus(0, 0, 16'd0, 1, 7'h04, 16'h0004);
    checkOutput("t6_done", 32'(b.done), 32'h1);
    checkOutput("t6_sig", 32'(b.signature), 32'h0004);
    checkOutput("t6_tog", 32'(b.toggle_count), 32'd5);
    checkOutput("t6_match", 32'(b.match), 32'h1);
    applyStimulus(0, 0, 16'd0, 0, 7'h00, 16'h0004);

    // Asynchronous reset in the middle of a capture window.
    applyStimulus(1, 0, 16'd4, 0, 7'h00, 16'h0000);
    applyStimulus(0, 0, 16'd0, 1, 7'h7F, 16'h0000);
    checkOutput("t7_pre_sig", 32'(b.signature), 32'h007F);
    #2;
    blif_reset_net = 1'b1;
    #1;
    checkOutput("t7_busy", 32'(b.busy), 32'h0);
    checkOutput("t7_sig", 32'(b.signature), 32'h0000);
    checkOutput("t7_tog", 32'(b.toggle_count), 32'h0);
    checkOutput("t7_done", 32'(b.done), 32'h0);
    b.start = 0; b.resp_valid = 0; b.resp_in = '0; b.num_cycles = '0;
    tick();
    blif_reset_net = 1'b0;
    tick();
    checkOutput("t7_after_busy", 32'(b.busy), 32'h0);
    checkOutput("t7_after_done", 32'(b.done), 32'h0);

    // Feedback tap: SEED 16'h8000 with a zero sample folds in POLY.
    applySat(1, 4'd1, 0, 7'h00, 16'h1021);
    applySat(0, 4'd0, 1, 7'h00, 16'h1021);
    checkOutput("t8_sig", 32'(bs.signature), 32'h1021);
    checkOutput("t8_done", 32'(bs.done), 32'h1);
    checkOutput("t8_match", 32'(bs.match), 32'h1);
    applySat(0, 4'd0, 0, 7'h00, 16'h1021);

    // Saturation on the 4-bit toggle counter: 7+7+7+7 clamps at 15.
    applySat(1, 4'd4, 0, 7'h00, 16'h820E);
    applySat(0, 4'd0, 1, 7'h7F, 16'h820E);
    checkOutput("t9_tog1", 32'(bs.toggle_count), 32'd7);
    checkOutput("t9_sig1", 32'(bs.signature), 32'h105E);
    applySat(0, 4'd0, 1, 7'h00, 16'h820E);
    checkOutput("t9_tog2", 32'(bs.toggle_count), 32'd14);
    checkOutput("t9_sig2", 32'(bs.signature), 32'h20BC);
    applySat(0, 4'd0, 1, 7'h7F, 16'h820E);
    checkOutput("t9_tog3", 32'(bs.toggle_count), 32'd15);
    checkOutput("t9_sig3", 32'(bs.signature), 32'h4107);
    applySat(0, 4'd0, 1, 7'h00, 16'h820E);
    checkOutput("t9_tog4", 32'(bs.toggle_count), 32'd15);
    checkOutput("t9_sig4", 32'(bs.signature), 32'h820E);
    checkOutput("t9_done", 32'(bs.done), 32'h1);
    checkOutput("t9_match", 32'(bs.match), 32'h1);
    applySat(0, 4'd0, 0, 7'h00, 16'h820E);
    checkOutput("t9_done_end", 32'(bs.done), 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/s386_resp_compactor.md
Name: s386_resp_compactor

Overview:
- Downstream response-compaction stage for the s386 sequential core.
- Consumes the core's 7 primary outputs v13_D_12..v13_D_6 over a programmable capture window.
- Folds them into a 16-bit MISR signature and a saturating output-toggle count; compares the signature with an expected value.
- Used in clock-mesh timing/variation runs to confirm the core produced the golden response sequence.

Parameters:
- RESP_W, 7, response bus width (core primary outputs)
- SIG_W, 16, MISR/signature width; must be >= RESP_W
- CNT_W, 16, width of window counter and toggle counter
- POLY, 16'h1021, MISR feedback polynomial (tap mask)
- SEED, 16'h0000, signature value loaded at start

Ports:
- blif_clk_net  in  1  clock, rising edge
- blif_reset_net  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a capture window; honoured only in IDLE
- abort  in  1  return to IDLE immediately; done is not pulsed
- num_cycles  in  CNT_W  number of valid response samples to compact; sampled on accepted start
- resp_valid  in  1  resp_in is a valid sample this cycle
- resp_in  in  RESP_W  {v13_D_12..v13_D_6}; bit 6 = v13_D_12, bit 0 = v13_D_6
- expected_sig  in  SIG_W  golden signature; sampled when DONE is entered
- busy  out  1  high in CAPTURE
- done  out  1  one-cycle pulse in DONE
- signature  out  SIG_W  current/final MISR value
- toggle_count  out  CNT_W  saturating sum of popcount(resp_in ^ previous sample)
- match  out  1  signature == expected_sig, registered on entry to DONE

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, signature=SEED, toggle_count=0, match=0, remaining=0, prev_resp=0.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - start=1 with num_cycles!=0: load signature=SEED, toggle_count=0, prev_resp=0, remaining=num_cycles; go to CAPTURE next cycle.
  - start=1 with num_cycles==0: signature=SEED, toggle_count=0; go to DONE.
  - Otherwise hold all outputs.
- CAPTURE (busy=1):
  - Each cycle with resp_valid=1:
    - signature <= {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(resp_in)
    - toggle_count <= min(toggle_count + popcount(resp_in ^ prev_resp), 2^CNT_W-1)
    - prev_resp <= resp_in
    - remaining decrements
  - resp_valid=0: everything holds; no sample is consumed.
  - Valid sample with remaining==1: go to DONE.
  - start in CAPTURE is ignored.
- DONE: done=1 for exactly one cycle; match <= (signature == expected_sig) using the final signature; unconditionally go to IDLE.
- signature, toggle_count and match hold in IDLE until the next accepted start; match clears to 0 on accepted start.
- abort has priority over start and resp_valid in every state. It forces IDLE next cycle and leaves signature/toggle_count at their current (partial) values. match=0, and done is not pulsed.
- Latency: the last valid sample is accepted in cycle N; done and match are valid in cycle N+1.
- Async reset mid-capture returns to the reset values immediately; no done pulse.
- All arithmetic is unsigned. The toggle counter saturates and never wraps. remaining never underflows.

Decomposition:
- Shared package s386_tb_pkg:
  - state enum (IDLE/CAPTURE/DONE)
  - RESP_W=7
  - default POLY and SEED constants
  - the bit-order mapping of resp_in onto v13_D_12..v13_D_6
- One sub-module, misr_reg (parameterised SIG_W, RESP_W, POLY), containing:
  - load (loads seed)
  - enable (performs one update)
  - in / sig ports
- The FSM, counters and popcount stay in the top.

Test Plan:
- Basic compaction: SEED=0, start with num_cycles=1, resp_in=7'h55 valid -> signature=16'h0055, toggle_count=4, done pulses one cycle later, busy is low after done.
- Feedback path: SEED=16'h8000, num_cycles=1, resp_in=0 -> signature=16'h1021. Separately, num_cycles=2 with samples 7'h55 then 7'h00 from SEED=0 -> 16'h00AA.
- Stall handling: num_cycles=2 with samples 7'h7F, (3 cycles resp_valid=0), 7'h00 -> toggle_count=14, done exactly one cycle after the second valid sample, no extra update during the stall.
- Zero window and compare: num_cycles=0, expected_sig=SEED -> DONE next cycle, match=1, signature=SEED. Repeat with expected_sig=SEED^1 -> match=0.
- Abort / ignored start: start num_cycles=5, two valid samples, then abort -> IDLE, no done, partial signature held. start asserted mid-capture in another run -> no restart, remaining count unaffected.
- Reset and saturation: blif_reset_net asserted mid-CAPTURE -> all outputs return to reset values asynchronously. With CNT_W=4, alternating 7'h7F/7'h00 for 4 samples -> toggle_count saturates at 15.
